// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot render sequencer.
package mandel_pkg;

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDrain} fsm_e;
  typedef enum logic [1:0] {SlotFree, SlotRunning, SlotHold} slot_e;

  localparam int unsigned DefWidth  = 400;
  localparam int unsigned DefHeight = 300;
  localparam int unsigned DefPixels = DefWidth * DefHeight;

  // Coordinate width; a single-entry dimension still needs one bit.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/serial_cfg_rx.sv
// Synchronises the RP2040 serial pins, shifts the config word LSB first and
// flags a falling sen edge as a start request.
module serial_cfg_rx #(
  parameter int unsigned CFG_BITS    = 58,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sen_in,
  input  logic                sclk_in,
  input  logic                sdata_in,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                start_req
);

  logic [SYNC_STAGES-1:0] sen_sync_q, sclk_sync_q, sdata_sync_q;
  logic                   sen_hist_q, sclk_hist_q;
  logic [CFG_BITS-1:0]    cfg_q, cfg_d;
  logic                   sen_s, sclk_s, sdata_s;

  assign sen_s   = sen_sync_q[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sen_sync_q   <= '0;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      sen_hist_q   <= 1'b0;
      sclk_hist_q  <= 1'b0;
      cfg_q        <= '0;
    end else begin
      sen_sync_q   <= {sen_sync_q[SYNC_STAGES-2:0], sen_in};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
      sen_hist_q   <= sen_s;
      sclk_hist_q  <= sclk_s;
      cfg_q        <= cfg_d;
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (sen_s && sclk_s && !sclk_hist_q) begin
      cfg_d = {sdata_s, cfg_q[CFG_BITS-1:1]};
    end
  end

  assign cfg_out   = cfg_q;
  assign start_req = sen_hist_q & ~sen_s;

endmodule

// File: rtl/mandel_render_seq.sv
// Frame sequencer: dispatches raster pixels round-robin to the engines and
// writes their results to the framebuffer strictly in pixel order.
module mandel_render_seq
  import mandel_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 2,
  parameter int unsigned CFG_BITS    = 58,
  parameter int unsigned WIDTH       = 400,
  parameter int unsigned HEIGHT      = 300,
  parameter int unsigned RESULT_W    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned XW         = coord_w(WIDTH),
  localparam int unsigned YW         = coord_w(HEIGHT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sen_in,
  input  logic                            sclk_in,
  input  logic                            sdata_in,
  output logic [CFG_BITS-1:0]             cfg_out,
  output logic [NUM_ENGINES-1:0]          eng_run,
  output logic [NUM_ENGINES*XW-1:0]       eng_x,
  output logic [NUM_ENGINES*YW-1:0]       eng_y,
  input  logic [NUM_ENGINES-1:0]          eng_running,
  input  logic [NUM_ENGINES*RESULT_W-1:0] eng_result,
  output logic                            fb_reset_ptr,
  output logic                            fb_write,
  output logic [RESULT_W-1:0]             fb_data,
  input  logic                            fb_wrote,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            start_dropped
);

  localparam int unsigned NPix    = pix_count(WIDTH, HEIGHT);
  localparam int unsigned NLaunch = (NPix < NUM_ENGINES) ? NPix : NUM_ENGINES;
  localparam int unsigned CW      = $clog2(NPix + 1);
  localparam int unsigned PW      = coord_w(NUM_ENGINES);

  fsm_e                      state_q, state_d;
  slot_e                     slot_q [NUM_ENGINES];
  slot_e                     slot_d [NUM_ENGINES];
  logic [RESULT_W-1:0]       res_q [NUM_ENGINES];
  logic [RESULT_W-1:0]       res_d [NUM_ENGINES];
  logic [NUM_ENGINES-1:0]    run_hist_q, fall, hold_now;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]             wr_cnt_q, wr_cnt_d, iss_cnt_q, iss_cnt_d;
  logic [XW-1:0]             iss_x_q, iss_x_d;
  logic [YW-1:0]             iss_y_q, iss_y_d;
  logic [NUM_ENGINES-1:0]    eng_run_q, eng_run_d;
  logic [NUM_ENGINES*XW-1:0] eng_x_q, eng_x_d;
  logic [NUM_ENGINES*YW-1:0] eng_y_q, eng_y_d;
  logic                      fb_write_q, fb_write_d;
  logic [RESULT_W-1:0]       fb_data_q, fb_data_d, wr_data;
  logic                      out_q, out_d, done_q, done_d, dropped_q, dropped_d;
  logic                      start_req, can_write;

  serial_cfg_rx #(
    .CFG_BITS    (CFG_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .sen_in    (sen_in),
    .sclk_in   (sclk_in),
    .sdata_in  (sdata_in),
    .cfg_out   (cfg_out),
    .start_req (start_req)
  );

  assign fall = run_hist_q & ~eng_running;

  // A slot whose engine is finishing this cycle counts as held, so its result
  // can be written on the very next cycle.
  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_slot
    assign hold_now[g] = (slot_q[g] == SlotHold) || ((slot_q[g] == SlotRunning) && fall[g]);
  end

  assign wr_data   = (slot_q[wr_ptr_q] == SlotHold) ? res_q[wr_ptr_q]
                                                    : eng_result[wr_ptr_q*RESULT_W +: RESULT_W];
  assign can_write = !fb_write_q && (!out_q || fb_wrote);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    res_d      = res_q;
    wr_ptr_d   = wr_ptr_q;
    wr_cnt_d   = wr_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    iss_x_d    = iss_x_q;
    iss_y_d    = iss_y_q;
    eng_run_d  = '0;
    eng_x_d    = eng_x_q;
    eng_y_d    = eng_y_q;
    fb_write_d = 1'b0;
    fb_data_d  = fb_data_q;
    done_d     = 1'b0;
    dropped_d  = dropped_q;
    out_d      = fb_write_q ? 1'b1 : (fb_wrote ? 1'b0 : out_q);

    for (int i = 0; i < NUM_ENGINES; i++) begin
      if ((slot_q[i] == SlotRunning) && fall[i]) begin
        slot_d[i] = SlotHold;
        res_d[i]  = eng_result[i*RESULT_W +: RESULT_W];
      end
    end

    if (start_req) dropped_d = (state_q != StIdle);

    unique case (state_q)
      StIdle: if (start_req) state_d = StClear;
      StClear: begin
        wr_ptr_d  = '0;
        wr_cnt_d  = '0;
        iss_cnt_d = CW'(NLaunch);
        iss_x_d   = XW'(NLaunch % WIDTH);
        iss_y_d   = YW'(NLaunch / WIDTH);
        for (int i = 0; i < NUM_ENGINES; i++) begin
          if (i < int'(NLaunch)) begin
            eng_run_d[i]          = 1'b1;
            eng_x_d[i*XW +: XW]   = XW'(i % WIDTH);
            eng_y_d[i*YW +: YW]   = YW'(i / WIDTH);
            slot_d[i]             = SlotRunning;
          end
        end
        state_d = StRun;
      end
      StRun: begin
        if (hold_now[wr_ptr_q] && can_write) begin
          fb_write_d       = 1'b1;
          fb_data_d        = wr_data;
          wr_cnt_d         = wr_cnt_q + 1'b1;
          wr_ptr_d         = (wr_ptr_q == PW'(NUM_ENGINES - 1)) ? '0 : wr_ptr_q + 1'b1;
          slot_d[wr_ptr_q] = SlotFree;
          if (iss_cnt_q < CW'(NPix)) begin
            slot_d[wr_ptr_q]            = SlotRunning;
            eng_run_d[wr_ptr_q]         = 1'b1;
            eng_x_d[wr_ptr_q*XW +: XW]  = iss_x_q;
            eng_y_d[wr_ptr_q*YW +: YW]  = iss_y_q;
            iss_cnt_d                   = iss_cnt_q + 1'b1;
            if (iss_x_q == XW'(WIDTH - 1)) begin
              iss_x_d = '0;
              iss_y_d = iss_y_q + 1'b1;
            end else begin
              iss_x_d = iss_x_q + 1'b1;
            end
          end
        end
        if (wr_cnt_q == CW'(NPix)) state_d = StDrain;
      end
      StDrain: begin
        if (fb_wrote && !fb_write_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      run_hist_q <= '0;
      wr_ptr_q   <= '0;
      wr_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      iss_x_q    <= '0;
      iss_y_q    <= '0;
      eng_run_q  <= '0;
      eng_x_q    <= '0;
      eng_y_q    <= '0;
      fb_write_q <= 1'b0;
      fb_data_q  <= '0;
      out_q      <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_q[i] <= SlotFree;
        res_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      run_hist_q <= eng_running;
      wr_ptr_q   <= wr_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      iss_x_q    <= iss_x_d;
      iss_y_q    <= iss_y_d;
      eng_run_q  <= eng_run_d;
      eng_x_q    <= eng_x_d;
      eng_y_q    <= eng_y_d;
      fb_write_q <= fb_write_d;
      fb_data_q  <= fb_data_d;
      out_q      <= out_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
      slot_q     <= slot_d;
      res_q      <= res_d;
    end
  end

  assign eng_run       = eng_run_q;
  assign eng_x         = eng_x_q;
  assign eng_y         = eng_y_q;
  assign fb_reset_ptr  = (state_q == StClear);
  assign fb_write      = fb_write_q;
  assign fb_data       = fb_data_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = done_q;
  assign start_dropped = dropped_q;

endmodule

// File: tb/tb_mandel_render_seq.sv
// Directed bench: a 4x2 frame on two engines and a 2x1 frame on four engines,
// with modelled fixed-latency engines and a one-cycle framebuffer ack.
module tb_mandel_render_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: 2 engines, 4x2 frame
  logic        sen_a = 1'b0, sclk_a = 1'b0, sdata_a = 1'b0;
  logic [57:0] cfg_a;
  logic [1:0]  run_a, running_a;
  logic [3:0]  x_a;
  logic [1:0]  y_a;
  logic [7:0]  result_a;
  logic        rptr_a, wr_a, wrote_a, busy_a, done_a, drop_a;
  logic [3:0]  data_a;

  // DUT B: 4 engines, 2x1 frame
  logic        sen_b = 1'b0, sclk_b = 1'b0, sdata_b = 1'b0;
  logic [57:0] cfg_b;
  logic [3:0]  run_b, running_b, x_b, y_b;
  logic [15:0] result_b;
  logic        rptr_b, wr_b, wrote_b, busy_b, done_b, drop_b;
  logic [3:0]  data_b;

  mandel_render_seq #(
    .NUM_ENGINES(2), .CFG_BITS(58), .WIDTH(4), .HEIGHT(2), .RESULT_W(4), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .sen_in(sen_a), .sclk_in(sclk_a), .sdata_in(sdata_a),
    .cfg_out(cfg_a), .eng_run(run_a), .eng_x(x_a), .eng_y(y_a),
    .eng_running(running_a), .eng_result(result_a), .fb_reset_ptr(rptr_a),
    .fb_write(wr_a), .fb_data(data_a), .fb_wrote(wrote_a), .busy(busy_a),
    .frame_done(done_a), .start_dropped(drop_a)
  );

  mandel_render_seq #(
    .NUM_ENGINES(4), .CFG_BITS(58), .WIDTH(2), .HEIGHT(1), .RESULT_W(4), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .sen_in(sen_b), .sclk_in(sclk_b), .sdata_in(sdata_b),
    .cfg_out(cfg_b), .eng_run(run_b), .eng_x(x_b), .eng_y(y_b),
    .eng_running(running_b), .eng_result(result_b), .fb_reset_ptr(rptr_b),
    .fb_write(wr_b), .fb_data(data_b), .fb_wrote(wrote_b), .busy(busy_b),
    .frame_done(done_b), .start_dropped(drop_b)
  );

  // Engine models: result = raster index y*WIDTH+x, busy for lat cycles.
  int         lat_a [2];
  logic       rl_a [2];
  int         cnt_a [2];
  logic [3:0] rs_a [2];
  for (genvar e = 0; e < 2; e++) begin : g_eng_a
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rl_a[e] <= 1'b0; cnt_a[e] <= 0; rs_a[e] <= 4'd0;
      end else if (run_a[e]) begin
        rl_a[e] <= 1'b1; cnt_a[e] <= lat_a[e]; rs_a[e] <= {1'b0, y_a[e], x_a[e*2 +: 2]};
      end else if (rl_a[e]) begin
        if (cnt_a[e] <= 1) rl_a[e] <= 1'b0;
        cnt_a[e] <= cnt_a[e] - 1;
      end
    end
    assign running_a[e]        = rl_a[e];
    assign result_a[e*4 +: 4]  = rs_a[e];
  end

  logic       rl_b [4];
  int         cnt_b [4];
  logic [3:0] rs_b [4];
  for (genvar e = 0; e < 4; e++) begin : g_eng_b
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rl_b[e] <= 1'b0; cnt_b[e] <= 0; rs_b[e] <= 4'd0;
      end else if (run_b[e]) begin
        rl_b[e] <= 1'b1; cnt_b[e] <= 2 + e; rs_b[e] <= {3'b000, x_b[e]};
      end else if (rl_b[e]) begin
        if (cnt_b[e] <= 1) rl_b[e] <= 1'b0;
        cnt_b[e] <= cnt_b[e] - 1;
      end
    end
    assign running_b[e]       = rl_b[e];
    assign result_b[e*4 +: 4] = rs_b[e];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wrote_a <= 1'b0; wrote_b <= 1'b0;
    end else begin
      wrote_a <= wr_a; wrote_b <= wr_b;
    end
  end

  // Frame capture for DUT A
  int         n_wr, n_rptr, n_done, clear_lat, first_wr_cyc, e1_fall_cyc;
  int         nrun_a [2];
  logic [3:0] wdata [8];
  logic       busy_at_done;

  task automatic frame_a(input int drop_at);
    int   done_cyc;
    logic prev1;
    n_wr = 0; n_rptr = 0; n_done = 0; clear_lat = -1; first_wr_cyc = -1; e1_fall_cyc = -1;
    nrun_a[0] = 0; nrun_a[1] = 0; busy_at_done = 1'b1; done_cyc = -1; prev1 = 1'b0;
    for (int k = 0; k < 8; k++) wdata[k] = 4'hF;
    sen_a = 1'b1;
    repeat (4) @(negedge clk);
    sen_a = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (drop_at > 0 && cyc == drop_at) sen_a = 1'b1;
      if (drop_at > 0 && cyc == drop_at + 4) sen_a = 1'b0;
      if (rptr_a) begin n_rptr++; if (clear_lat < 0) clear_lat = cyc; end
      if (wr_a) begin
        if (n_wr < 8) wdata[n_wr] = data_a;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        n_wr++;
      end
      if (prev1 && !running_a[1] && e1_fall_cyc < 0) e1_fall_cyc = cyc;
      prev1 = running_a[1];
      for (int e = 0; e < 2; e++) if (run_a[e]) nrun_a[e]++;
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy_a; end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL frame_timeout: got no frame_done, required one within 300 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_a, run_a, x_a, y_a, rptr_a, wr_a, data_a, busy_a, done_a, drop_a} !== '0) begin
      failures++; $display("FAIL reset_outputs_a: got nonzero, required all zero");
    end
    checks++;
    if ({cfg_b, run_b, x_b, y_b, rptr_b, wr_b, data_b, busy_b, done_b, drop_b} !== '0) begin
      failures++; $display("FAIL reset_outputs_b: got nonzero, required all zero");
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got %b required 0", busy_a); end
  endtask

  task automatic test_serial_cfg();
    logic [59:0] lit;
    logic [57:0] val, pre;
    int          saw_busy;
    lit = 60'h2AAAAAAAAAAAAAA; val = lit[57:0]; pre = val << 1; saw_busy = 0;
    sen_a = 1'b1; sclk_a = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < 58; b++) begin
      sdata_a = val[b];
      for (int k = 0; k < 3; k++) begin @(negedge clk); if (busy_a) saw_busy++; end
      sclk_a = 1'b1;
      if (b == 57) begin
        repeat (2) @(negedge clk);
        checks++;
        if (cfg_a !== pre) begin failures++; $display("FAIL cfg_before_last_shift: got %h required %h", cfg_a, pre); end
        @(negedge clk);
        checks++;
        if (cfg_a !== val) begin failures++; $display("FAIL cfg_value: got %h required %h", cfg_a, val); end
      end else begin
        repeat (3) @(negedge clk);
      end
      sclk_a = 1'b0;
      for (int k = 0; k < 3; k++) begin @(negedge clk); if (busy_a) saw_busy++; end
    end
    checks++;
    if (saw_busy != 0) begin failures++; $display("FAIL no_start_while_sen_high: got %0d busy cycles required 0", saw_busy); end
    checks++;
    if (drop_a !== 1'b0) begin failures++; $display("FAIL no_drop_while_sen_high: got %b required 0", drop_a); end
  endtask

  task automatic test_frame_order();
    lat_a[0] = 3; lat_a[1] = 7;
    frame_a(0);
    checks++;
    if (clear_lat != 3) begin failures++; $display("FAIL sen_to_clear: got %0d required 3", clear_lat); end
    checks++;
    if (n_rptr != 1) begin failures++; $display("FAIL reset_ptr_count: got %0d required 1", n_rptr); end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL frame_done_count: got %0d required 1", n_done); end
    checks++;
    if (n_wr != 8) begin failures++; $display("FAIL write_count: got %0d required 8", n_wr); end
    checks++;
    if (busy_at_done !== 1'b0) begin failures++; $display("FAIL busy_at_done: got %b required 0", busy_at_done); end
    checks++;
    if (nrun_a[0] != 4 || nrun_a[1] != 4) begin
      failures++; $display("FAIL launches: got %0d/%0d required 4/4", nrun_a[0], nrun_a[1]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wdata[k] !== 4'(k)) begin failures++; $display("FAIL write_data[%0d]: got %0d required %0d", k, wdata[k], k); end
    end
  endtask

  task automatic test_out_of_order();
    lat_a[0] = 7; lat_a[1] = 3;
    frame_a(0);
    checks++;
    if (n_wr != 8) begin failures++; $display("FAIL ooo_write_count: got %0d required 8", n_wr); end
    // Engine 1 finishes at cycle 8, engine 0 at 12; writes must wait for pixel 0.
    checks++;
    if (e1_fall_cyc != 8 || first_wr_cyc != 13) begin
      failures++;
      $display("FAIL ooo_hold: got e1 fall %0d first write %0d required 8 and 13", e1_fall_cyc, first_wr_cyc);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wdata[k] !== 4'(k)) begin failures++; $display("FAIL ooo_data[%0d]: got %0d required %0d", k, wdata[k], k); end
    end
  endtask

  task automatic test_start_while_busy();
    lat_a[0] = 3; lat_a[1] = 7;
    frame_a(5);
    checks++;
    if (drop_a !== 1'b1) begin failures++; $display("FAIL start_dropped_set: got %b required 1", drop_a); end
    checks++;
    if (n_wr != 8 || n_done != 1 || n_rptr != 1) begin
      failures++; $display("FAIL frame_with_drop: got wr %0d done %0d rptr %0d required 8 1 1", n_wr, n_done, n_rptr);
    end
    checks++;
    if (wdata[7] !== 4'd7) begin failures++; $display("FAIL drop_last_data: got %0d required 7", wdata[7]); end
    frame_a(0);
    checks++;
    if (drop_a !== 1'b0) begin failures++; $display("FAIL start_dropped_clear: got %b required 0", drop_a); end
  endtask

  task automatic test_reset_mid_frame();
    lat_a[0] = 3; lat_a[1] = 7;
    sen_a = 1'b1;
    repeat (4) @(negedge clk);
    sen_a = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_frame_busy: got %b required 1", busy_a); end
    rst = 1'b1;
    #1;
    checks++;
    if ({cfg_a, run_a, x_a, y_a, rptr_a, wr_a, data_a, busy_a, done_a, drop_a} !== '0) begin
      failures++; $display("FAIL abort_outputs: got nonzero, required all zero");
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_a(0);
    checks++;
    if (n_wr != 8 || n_done != 1) begin
      failures++; $display("FAIL after_abort_frame: got wr %0d done %0d required 8 1", n_wr, n_done);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wdata[k] !== 4'(k)) begin failures++; $display("FAIL abort_data[%0d]: got %0d required %0d", k, wdata[k], k); end
    end
  endtask

  task automatic test_small_frame();
    int         nw, nd, done_cyc;
    int         nr [4];
    logic [3:0] d [2];
    nw = 0; nd = 0; done_cyc = -1; d[0] = 4'hF; d[1] = 4'hF;
    for (int e = 0; e < 4; e++) nr[e] = 0;
    sen_b = 1'b1;
    repeat (4) @(negedge clk);
    sen_b = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (wr_b) begin if (nw < 2) d[nw] = data_b; nw++; end
      for (int e = 0; e < 4; e++) if (run_b[e]) nr[e]++;
      if (done_b) begin nd++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    checks++;
    if (nr[0] != 1 || nr[1] != 1 || nr[2] != 0 || nr[3] != 0) begin
      failures++; $display("FAIL small_launches: got %0d %0d %0d %0d required 1 1 0 0", nr[0], nr[1], nr[2], nr[3]);
    end
    checks++;
    if (nw != 2) begin failures++; $display("FAIL small_write_count: got %0d required 2", nw); end
    checks++;
    if (d[0] !== 4'd0 || d[1] !== 4'd1) begin
      failures++; $display("FAIL small_data: got %0d %0d required 0 1", d[0], d[1]);
    end
    checks++;
    if (nd != 1) begin failures++; $display("FAIL small_frame_done: got %0d required 1", nd); end
  endtask

  initial begin
    lat_a[0] = 3; lat_a[1] = 7;
    test_reset();
    test_serial_cfg();
    test_frame_order();
    test_out_of_order();
    test_start_while_busy();
    test_reset_mid_frame();
    test_small_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_render_seq.md
# mandel_render_seq

Parametrised render sequencer for the tiny Mandelbrot design. It sits between the RP2040 control pins, a bank of `NUM_ENGINES` Mandelbrot pixel engines and the VGA framebuffer write port. It receives the serial configuration word and starts a frame on command. It dispatches raster-ordered pixel jobs to the engines round-robin and writes the results to the framebuffer strictly in raster order through the `fb_write`/`fb_wrote` handshake.

## Interface
- `NUM_ENGINES`, 2: number of pixel engines; 1..8.
- `CFG_BITS`, 58: configuration shift-register length.
- `WIDTH`, 400: pixels per line.
- `HEIGHT`, 300: lines per frame.
- `RESULT_W`, 4: engine result width written to the framebuffer.
- `SYNC_STAGES`, 2: synchroniser depth on the serial pins; minimum 2.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sen_in`, `sclk_in`, `sdata_in`  in  1 each  asynchronous serial enable, clock and data.
- `cfg_out`  out  `CFG_BITS`  current configuration word.
- `eng_run`  out  `NUM_ENGINES`  one-cycle start pulse per engine.
- `eng_x`  out  `NUM_ENGINES*XW`  pixel column per engine, `XW=$clog2(WIDTH)`.
- `eng_y`  out  `NUM_ENGINES*YW`  pixel row per engine, `YW=$clog2(HEIGHT)`.
- `eng_running`  in  `NUM_ENGINES`  engine busy level.
- `eng_result`  in  `NUM_ENGINES*RESULT_W`  engine result; valid on the falling edge of `eng_running`.
- `fb_reset_ptr`  out  1  one-cycle framebuffer write-pointer reset.
- `fb_write`  out  1  one-cycle write strobe.
- `fb_data`  out  `RESULT_W`  write data.
- `fb_wrote`  in  1  framebuffer is ready for the next write.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at frame completion.
- `start_dropped`  out  1  sticky flag: a start request arrived while busy.

## Operation
- **Serial receiver:** each pin passes through a `SYNC_STAGES` synchroniser plus one history flop.
  - On a rising `sclk` edge while `sen` is high: `cfg <= {sdata, cfg[CFG_BITS-1:1]}` (LSB first).
  - A falling `sen` edge is a start request.
- **Main FSM:** IDLE, CLEAR, RUN, DRAIN.
  - IDLE: a start request moves to CLEAR.
  - CLEAR (one cycle): `fb_reset_ptr=1`; launches engines 0..L-1 with pixels 0..L-1, where `L=min(NUM_ENGINES, WIDTH*HEIGHT)`; moves to RUN.
  - RUN: once every pixel has been written, moves to DRAIN.
  - DRAIN: waits for `fb_wrote`, then pulses `frame_done` and returns to IDLE.
  - `busy` is high in CLEAR, RUN and DRAIN.
- **Per-engine slot:** states FREE, RUNNING, HOLD.
  - RUNNING→HOLD on the registered falling edge of `eng_running`; `eng_result` is captured into the slot.
  - A falling edge while the slot is not RUNNING is ignored.
- **Collector:** round-robin pointer `wr_ptr`, starting at 0.
  - A write fires when slot[`wr_ptr`] is in HOLD and no write is outstanding.
  - On a write: `fb_write=1`, `fb_data=` slot result, slot→FREE, `wr_ptr` advances modulo `NUM_ENGINES`.
  - In the same cycle, if issue count < `WIDTH*HEIGHT`, the freed slot relaunches with the next raster pixel. The issue pixel advances x first; x wraps at `WIDTH-1` and increments y.
- **Outstanding write:** set by `fb_write`, cleared by `fb_wrote`.
- **Ordering:** results are written strictly in pixel order regardless of engine completion order.
- **Start while busy:** ignored; sets `start_dropped`, which clears on the next accepted start.
- **Config during a frame:** shifting continues, and engines see the live `cfg_out`. Freezing the configuration is the host's responsibility.
- **Reset values:** all outputs 0, `cfg_out` = 0, FSM IDLE, slots FREE, counters 0. An asserted `rst` aborts any frame immediately.

## Timing
- `sclk` edge at the pin to `cfg_out` update: `SYNC_STAGES+1` cycles.
- `sen` fall at the pin to CLEAR: `SYNC_STAGES+1` cycles.
- `eng_run` and `eng_x`/`eng_y` are registered. The coordinates are valid in the `eng_run` cycle and hold until that engine's next launch.
- `eng_running` falling edge (cycle t): slot in HOLD at t+1. The earliest `fb_write` is at t+1 if the slot is at `wr_ptr` and nothing is outstanding.
- `fb_wrote` at cycle t: the next `fb_write` can occur no earlier than t+1.
- Relaunch `eng_run` occurs in the same cycle as the `fb_write` that frees the slot.
- `frame_done` occurs in the cycle after the final `fb_wrote`; `busy` is low in that same cycle.

## Structure
- Package `mandel_pkg`:
  - FSM and slot state enums.
  - `XW`/`YW` derivation functions.
  - Pixel-count constant `WIDTH*HEIGHT`.
- Sub-module `serial_cfg_rx`: synchronisers, edge detection, shift register, start-request pulse.
- Slot array, collector and FSM live in the top level via generate loops.

## Test plan
- Shift 58 bits of `0x2AAAAAAAAAAAAAA` LSB first with `sen` high -> `cfg_out` equals that value; no start request while `sen` stays high.
- `WIDTH=4`, `HEIGHT=2`, `NUM_ENGINES=2`, engines with fixed latencies of 3 and 7 cycles, `fb_wrote` one cycle after each write -> exactly 8 `fb_write` pulses with data 0..7 in pixel order; one `fb_reset_ptr`; one `frame_done`.
- Engine 1 finishes before engine 0 -> engine 1's result is held until engine 0's result is written; order is preserved.
- `NUM_ENGINES=4`, `WIDTH*HEIGHT=2` -> only engines 0 and 1 receive `eng_run`; 2 writes; `frame_done`.
- Second `sen` falling edge mid-frame -> frame unaffected, `start_dropped=1`; the next start after `frame_done` clears it.
- Assert `rst` mid-frame -> in the same cycle all outputs are 0 and the FSM is IDLE; a new start request renders a full frame from pixel 0.
